// File: rtl/bcd_scan_pkg.sv
// rtl/bcd_scan_pkg.sv - shared types and constants for the multiplexed 7-segment scan driver
//
// Purpose : scan FSM state encoding, the pre-polarity "all segments off" pattern,
//           and a ceil(log2) width helper for sizing counters and indices.
// Ports   : none (package).
package bcd_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  // Bits needed to count 0..value-1; never less than 1 so vectors stay legal.
  function automatic int clog2_w(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bcd_7segment.sv
// rtl/bcd_7segment.sv - combinational BCD/hex digit to 7-segment decoder
//
// Purpose : maps a 4-bit code to active-high segments {a,b,c,d,e,f,g}.
//           Codes 10..15 decode to hex glyphs A, b, C, d, E, F.
// Ports   : bcd     in  4  digit code
//           segment out 7  {a,b,c,d,e,f,g}, 1 = lit
module bcd_7segment (
  input  logic [3:0] bcd,
  output logic [6:0] segment
);

  always_comb begin
    segment = 7'h00;
    case (bcd)
      4'h0: segment = 7'h7E;
      4'h1: segment = 7'h30;
      4'h2: segment = 7'h6D;
      4'h3: segment = 7'h79;
      4'h4: segment = 7'h33;
      4'h5: segment = 7'h5B;
      4'h6: segment = 7'h5F;
      4'h7: segment = 7'h70;
      4'h8: segment = 7'h7F;
      4'h9: segment = 7'h7B;
      4'hA: segment = 7'h77;
      4'hB: segment = 7'h1F;
      4'hC: segment = 7'h4E;
      4'hD: segment = 7'h3D;
      4'hE: segment = 7'h4F;
      4'hF: segment = 7'h47;
      default: segment = 7'h00;
    endcase
  end

endmodule

// File: rtl/bcd_scan_driver.sv
// rtl/bcd_scan_driver.sv - multiplexed multi-digit 7-segment scan driver with blanking guard
//
// Purpose : snapshots NUM_DIGITS packed BCD digits once per frame and scans them
//           one at a time; each digit slot is BLANK_CYCLES dark followed by
//           SCAN_DIV-BLANK_CYCLES with the digit enabled.
// Ports   : clk        in  1             system clock
//           rst        in  1             synchronous active-high reset
//           enable     in  1             scan enable, low = display dark
//           bcd_in     in  4*NUM_DIGITS  packed digits, digit 0 = bcd_in[3:0] (rightmost)
//           segment    out 7             {a,b,c,d,e,f,g} after polarity, registered
//           digit_sel  out NUM_DIGITS    one-hot digit enable after polarity, registered
//           frame_done out 1             one-cycle pulse on the first BLANK cycle of a new frame
// Options : `define LEADING_ZERO_BLANK_EN to darken leading zero digits (digit 0 always shown).
module bcd_scan_driver
  import bcd_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  output logic [6:0]              segment,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int CW = clog2_w(SCAN_DIV);
  localparam int IW = clog2_w(NUM_DIGITS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // XOR masks applied as values enter the output registers.
  localparam logic [6:0]            SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_XOR = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  scan_state_t             state;
  logic [IW-1:0]           idx;
  logic [CW-1:0]           cnt;
  logic [4*NUM_DIGITS-1:0] snap;

  // Index and snapshot as they will be after this edge; the decoder looks at
  // these so the segment register already holds the new digit during BLANK.
  logic [IW-1:0]           next_idx;
  logic [4*NUM_DIGITS-1:0] next_snap;
  logic [3:0]              mux_digit;
  logic [6:0]              dec_seg;
  logic [6:0]              digit_seg;
  logic                    show_end;

  assign show_end = (state == SHOW) && (cnt == SHOW_LAST);

  always_comb begin
    next_idx  = idx;
    next_snap = snap;
    if (state == IDLE) begin
      next_idx  = '0;
      next_snap = bcd_in;
    end else if (show_end) begin
      if (idx == IDX_LAST) begin
        next_idx  = '0;
        next_snap = bcd_in;
      end else begin
        next_idx = idx + 1'b1;
      end
    end
  end

  assign mux_digit = next_snap[4*int'(next_idx) +: 4];

  bcd_7segment u_dec (
    .bcd     (mux_digit),
    .segment (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[i] is set when digit i and every digit above it are zero.
  logic [NUM_DIGITS-1:0] lead_zero;

  always_comb begin
    logic run;
    lead_zero = '0;
    run       = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run          = run && (next_snap[4*i +: 4] == 4'd0);
      lead_zero[i] = run;
    end
  end

  assign digit_seg = lead_zero[next_idx] ? SEG_OFF : dec_seg;
`else
  assign digit_seg = dec_seg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      snap       <= '0;
      segment    <= SEG_OFF ^ SEG_XOR;
      digit_sel  <= DIG_XOR;
      frame_done <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      segment    <= SEG_OFF ^ SEG_XOR;
      digit_sel  <= DIG_XOR;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          state     <= BLANK;
          idx       <= next_idx;
          snap      <= next_snap;
          cnt       <= '0;
          segment   <= digit_seg ^ SEG_XOR;
          digit_sel <= DIG_XOR;
        end
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state     <= SHOW;
            cnt       <= '0;
            digit_sel <= (NUM_DIGITS'(1) << idx) ^ DIG_XOR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (show_end) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= next_idx;
            snap       <= next_snap;
            segment    <= digit_seg ^ SEG_XOR;
            digit_sel  <= DIG_XOR;
            frame_done <= (idx == IDX_LAST);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          idx       <= '0;
          cnt       <= '0;
          segment   <= SEG_OFF ^ SEG_XOR;
          digit_sel <= DIG_XOR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb/tb_bcd_scan_driver.sv - scoreboard bench for bcd_scan_driver (4 digits, 8-clock slots, 2 blank)
module tb_bcd_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] bcd_in;
  logic [6:0]  segment;
  logic [3:0]  digit_sel;
  logic        frame_done;

  always #5 clk = ~clk;

  bcd_scan_driver #(
    .NUM_DIGITS     (4),
    .SCAN_DIV       (8),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .bcd_in     (bcd_in),
    .segment    (segment),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  // Common-anode (inverted) segment codes, computed by hand.
  localparam logic [6:0] S0  = 7'h01;
  localparam logic [6:0] S1  = 7'h4F;
  localparam logic [6:0] S2  = 7'h12;
  localparam logic [6:0] S3  = 7'h06;
  localparam logic [6:0] S4  = 7'h4C;
  localparam logic [6:0] S5  = 7'h24;
  localparam logic [6:0] S6  = 7'h20;
  localparam logic [6:0] S7  = 7'h0F;
  localparam logic [6:0] S8  = 7'h00;
  localparam logic [6:0] OFF = 7'h7F;
  localparam logic [3:0] DOFF = 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = OFF;
`else
  localparam logic [6:0] LZ = S0;
`endif

  typedef struct {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       fd;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Monitor: one expectation per clock, compared mid-cycle.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (segment !== e.seg || digit_sel !== e.dig || frame_done !== e.fd) begin
          n_fail++;
          $display("FAIL %s @%0t: got seg=%h dig=%h fd=%b, required seg=%h dig=%h fd=%b",
                   e.name, $time, segment, digit_sel, frame_done, e.seg, e.dig, e.fd);
        end
      end
    end
  end

  function automatic logic [3:0] sel(input int k);
    logic [3:0] one;
    one = 4'b0001 << k;
    return ~one;
  endfunction

  // Advance one clock, then record what the outputs must be after that edge.
  task automatic cyc(input logic [6:0] s, input logic [3:0] d, input logic f, input string n);
    exp_t e;
    @(posedge clk);
    #1;
    e.seg = s;
    e.dig = d;
    e.fd  = f;
    e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic blank_part(input logic [6:0] s, input logic f, input string n);
    cyc(s, DOFF, f, n);
    cyc(s, DOFF, 1'b0, n);
  endtask

  task automatic show_part(input int k, input logic [6:0] s, input int count, input string n);
    repeat (count) cyc(s, sel(k), 1'b0, n);
  endtask

  task automatic slot(input int k, input logic [6:0] s, input logic f, input string n);
    blank_part(s, f, n);
    show_part(k, s, 6, n);
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input logic f, input string n);
    slot(0, s0, f, n);
    slot(1, s1, 1'b0, n);
    slot(2, s2, 1'b0, n);
    slot(3, s3, 1'b0, n);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    bcd_in = 16'h0000;

    // Reset and idle
    repeat (2) cyc(OFF, DOFF, 1'b0, "reset");
    rst = 1'b0;
    repeat (20) cyc(OFF, DOFF, 1'b0, "idle");

    // Basic scan, two frames
    bcd_in = 16'h1234;
    enable = 1'b1;
    frame(S4, S3, S2, S1, 1'b0, "scan_f1");
    frame(S4, S3, S2, S1, 1'b1, "scan_f2");

    // Tear-free update during digit 2 SHOW
    slot(0, S4, 1'b1, "tear_f3");
    slot(1, S3, 1'b0, "tear_f3");
    blank_part(S2, 1'b0, "tear_f3");
    show_part(2, S2, 3, "tear_f3");
    bcd_in = 16'h5678;
    show_part(2, S2, 3, "tear_hold");
    slot(3, S1, 1'b0, "tear_hold");
    frame(S8, S7, S6, S5, 1'b1, "new_frame");

    // Enable drop during digit 1 SHOW
    slot(0, S8, 1'b1, "en_drop");
    blank_part(S7, 1'b0, "en_drop");
    show_part(1, S7, 3, "en_drop");
    enable = 1'b0;
    bcd_in = 16'h1234;
    repeat (4) cyc(OFF, DOFF, 1'b0, "disabled");
    enable = 1'b1;
    frame(S4, S3, S2, S1, 1'b0, "re_enable");

    // Mid-scan reset during digit 3 SHOW (rst wins over enable)
    slot(0, S4, 1'b1, "pre_rst");
    slot(1, S3, 1'b0, "pre_rst");
    slot(2, S2, 1'b0, "pre_rst");
    blank_part(S1, 1'b0, "pre_rst");
    show_part(3, S1, 2, "pre_rst");
    rst = 1'b1;
    repeat (2) cyc(OFF, DOFF, 1'b0, "mid_rst");
    bcd_in = 16'h0070;
    rst = 1'b0;

    // Leading zeros: 0070 then 0000
    slot(0, S0, 1'b0, "lz_0070");
    bcd_in = 16'h0000;
    slot(1, S7, 1'b0, "lz_0070");
    slot(2, LZ, 1'b0, "lz_0070");
    slot(3, LZ, 1'b0, "lz_0070");
    frame(S0, LZ, LZ, LZ, 1'b1, "lz_0000");

    enable = 1'b0;
    repeat (2) cyc(OFF, DOFF, 1'b0, "final_off");

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
